// File: rtl/mem_arbiter_if.sv
// Bus bundle between the instruction/data caches, the arbiter and the RAM.
// Handshake: a requester holds xREN/xWEN until its xwait goes low; that cycle is the completion cycle and xload is valid in it.
interface mem_arbiter_if;
    logic        iREN;
    logic [31:0] iaddr;
    logic        dREN;
    logic        dWEN;
    logic [31:0] daddr;
    logic [31:0] dstore;
    logic [31:0] ramload;
    logic [1:0]  ramstate;
    logic        iwait;
    logic        dwait;
    logic [31:0] iload;
    logic [31:0] dload;
    logic        ramREN;
    logic        ramWEN;
    logic [31:0] ramaddr;
    logic [31:0] ramstore;
    logic        memerr;

    modport slave (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        output iwait, dwait, iload, dload, ramREN, ramWEN, ramaddr, ramstore, memerr
    );

    modport master (
        output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        input  iwait, dwait, iload, dload, ramREN, ramWEN, ramaddr, ramstore, memerr
    );
endinterface

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter for instruction and data caches: data has priority, with
// a starvation guard for instruction fetches and a grant timeout that aborts and re-arbitrates.
module mem_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int TIMEOUT      = 15
) (
    input  logic         clk,
    input  logic         rst,
    mem_arbiter_if.slave bus,
    output logic [1:0]   dbgState
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        IGNT  = 2'd1,
        DGNT  = 2'd2,
        ABORT = 2'd3
    } state_t;

    localparam int          SW         = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
    localparam logic [3:0]  TOUT_LAST  = 4'(TIMEOUT - 1);
    localparam logic [1:0]  RAM_ACCESS = 2'd2;
    localparam logic [1:0]  RAM_ERROR  = 2'd3;

    state_t        state;
    state_t        nextState;
    logic [SW-1:0] starveCnt;
    logic [3:0]    toutCnt;
    logic          dReq;
    logic          ramDone;
    logic          ramErr;
    logic          grantReq;
    logic          iDone;
    logic          dDone;

    assign dReq    = bus.dREN | bus.dWEN;
    assign ramErr  = (bus.ramstate == RAM_ERROR);
    assign ramDone = (bus.ramstate == RAM_ACCESS) | ramErr;

    always_comb begin
        nextState    = state;
        grantReq     = 1'b0;
        iDone        = 1'b0;
        dDone        = 1'b0;
        bus.ramREN   = 1'b0;
        bus.ramWEN   = 1'b0;
        bus.ramaddr  = '0;
        bus.ramstore = '0;
        bus.memerr   = 1'b0;
        case (state)
            IDLE: begin
                if (dReq && !(bus.iREN && starveCnt == STARVE_MAX)) nextState = DGNT;
                else if (bus.iREN)                                  nextState = IGNT;
            end
            IGNT: begin
                grantReq    = bus.iREN;
                bus.ramREN  = bus.iREN;
                bus.ramaddr = bus.iaddr;
                iDone       = bus.iREN & ramDone;
                bus.memerr  = iDone & ramErr;
            end
            DGNT: begin
                grantReq     = dReq;
                bus.ramWEN   = bus.dWEN;
                bus.ramREN   = bus.dREN & ~bus.dWEN;
                bus.ramaddr  = bus.daddr;
                bus.ramstore = bus.dstore;
                dDone        = dReq & ramDone;
                bus.memerr   = dDone & ramErr;
            end
            ABORT: begin
                bus.memerr = 1'b1;
                nextState  = IDLE;
            end
            default: nextState = IDLE;
        endcase
        // A dropped request or a completion ends the grant; otherwise the 15th idle grant cycle aborts.
        if (state == IGNT || state == DGNT) begin
            if (!grantReq || ramDone)   nextState = IDLE;
            else if (toutCnt == TOUT_LAST) nextState = ABORT;
        end
    end

    assign bus.iwait = bus.iREN & ~iDone;
    assign bus.dwait = dReq & ~dDone;
    assign bus.iload = iDone ? bus.ramload : 32'd0;
    assign bus.dload = dDone ? bus.ramload : 32'd0;
    assign dbgState  = state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            starveCnt <= '0;
            toutCnt   <= '0;
        end else begin
            state <= nextState;
            if (state == IDLE) begin
                toutCnt <= '0;
                if (nextState == IGNT || !bus.iREN)                   starveCnt <= '0;
                else if (nextState == DGNT && starveCnt != STARVE_MAX) starveCnt <= starveCnt + 1'b1;
            end else if ((state == IGNT || state == DGNT) && !ramDone) begin
                toutCnt <= toutCnt + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: stimulus pushes expected completion/abort events,
// a negedge monitor pops and compares them; inline checks cover strobes and state.
module tb_mem_arbiter;
    localparam int         W     = 51;
    localparam logic [1:0] K_I   = 2'd1;
    localparam logic [1:0] K_D   = 2'd2;
    localparam logic [1:0] K_ABT = 2'd3;
    localparam logic [1:0] S_IDLE = 2'd0, S_IGNT = 2'd1, S_DGNT = 2'd2, S_ABORT = 2'd3;
    localparam logic [1:0] R_FREE = 2'd0, R_BUSY = 2'd1, R_ACCESS = 2'd2, R_ERROR = 2'd3;

    logic          clk;
    logic          rst;
    logic [1:0]    dbgState;
    logic [15:0]   cyc = '0;
    logic [W-1:0]  exp_q[$];
    logic [W-1:0]  mon_got;
    logic [W-1:0]  mon_exp;
    logic          mon_hit;
    int            checks = 0;
    int            failures = 0;
    logic [1:0]    st_tab [13] = '{S_IDLE, S_DGNT, S_IDLE, S_DGNT, S_IDLE, S_DGNT, S_IDLE,
                                   S_DGNT, S_IDLE, S_IGNT, S_IDLE, S_DGNT, S_IDLE};

    mem_arbiter_if bus ();

    mem_arbiter #(.STARVE_LIMIT(4), .TIMEOUT(15)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus),
        .dbgState(dbgState)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 16'd1;

    // driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic idle_bus();
        bus.iREN     = 1'b0;
        bus.iaddr    = '0;
        bus.dREN     = 1'b0;
        bus.dWEN     = 1'b0;
        bus.daddr    = '0;
        bus.dstore   = '0;
        bus.ramload  = '0;
        bus.ramstate = R_FREE;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic expect_ev(input logic [1:0] kind, input logic err, input logic [15:0] c,
                             input logic [31:0] load);
        exp_q.push_back({kind, err, c, load});
    endtask

    // scoreboard monitor: {kind, memerr, cycle, load}
    always @(negedge clk) begin
        mon_hit = 1'b0;
        mon_got = '0;
        if (bus.iREN === 1'b1 && bus.iwait === 1'b0) begin
            mon_hit = 1'b1;
            mon_got = {K_I, bus.memerr, cyc, bus.iload};
        end else if ((bus.dREN | bus.dWEN) === 1'b1 && bus.dwait === 1'b0) begin
            mon_hit = 1'b1;
            mon_got = {K_D, bus.memerr, cyc, bus.dload};
        end else if (bus.memerr === 1'b1) begin
            mon_hit = 1'b1;
            mon_got = {K_ABT, 1'b1, cyc, bus.iload | bus.dload};
        end
        if (mon_hit) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL event: got unexpected %h expected none", mon_got);
            end else begin
                mon_exp = exp_q.pop_front();
                if (mon_got !== mon_exp) begin
                    failures++;
                    $display("FAIL event: got %h expected %h", mon_got, mon_exp);
                end
            end
        end
    end

    initial begin
        logic [15:0] c;
        idle_bus();
        rst = 1'b1;
        // reset: outputs quiet, waits follow requests
        bus.iREN = 1'b1;
        bus.dREN = 1'b1;
        bus.iaddr = 32'h10;
        bus.daddr = 32'h20;
        bus.dstore = 32'h55;
        bus.ramstate = R_ACCESS;
        step();
        step();
        mid();
        chk("rst_state", dbgState, S_IDLE);
        chk("rst_ramREN", bus.ramREN, 0);
        chk("rst_ramWEN", bus.ramWEN, 0);
        chk("rst_memerr", bus.memerr, 0);
        chk("rst_ramaddr", bus.ramaddr, 0);
        chk("rst_ramstore", bus.ramstore, 0);
        chk("rst_loads", bus.iload | bus.dload, 0);
        chk("rst_iwait", bus.iwait, 1);
        chk("rst_dwait", bus.dwait, 1);
        step();
        rst = 1'b0;
        idle_bus();
        step();
        step();

        // single instruction read, minimum latency
        c = cyc;
        bus.iREN = 1'b1;
        bus.iaddr = 32'h40;
        expect_ev(K_I, 1'b0, c + 16'd1, 32'hDEAD);
        step();
        bus.ramstate = R_ACCESS;
        bus.ramload = 32'hDEAD;
        mid();
        chk("i1_state", dbgState, S_IGNT);
        chk("i1_ramREN", bus.ramREN, 1);
        chk("i1_ramaddr", bus.ramaddr, 32'h40);
        chk("i1_iwait", bus.iwait, 0);
        chk("i1_iload", bus.iload, 32'hDEAD);
        step();
        idle_bus();
        mid();
        chk("i1_back_idle", dbgState, S_IDLE);
        step();

        // data write beats pending instruction, two BUSY cycles
        c = cyc;
        bus.iREN = 1'b1;
        bus.iaddr = 32'h44;
        bus.dWEN = 1'b1;
        bus.daddr = 32'h80;
        bus.dstore = 32'h1234;
        expect_ev(K_D, 1'b0, c + 16'd3, 32'h0);
        expect_ev(K_I, 1'b0, c + 16'd5, 32'hCAFE);
        step();
        bus.ramstate = R_BUSY;
        mid();
        chk("w_state", dbgState, S_DGNT);
        chk("w_ramWEN", bus.ramWEN, 1);
        chk("w_ramREN", bus.ramREN, 0);
        chk("w_ramstore", bus.ramstore, 32'h1234);
        chk("w_ramaddr", bus.ramaddr, 32'h80);
        chk("w_iwait", bus.iwait, 1);
        step();
        mid();
        chk("w_dwait_busy", bus.dwait, 1);
        step();
        bus.ramstate = R_ACCESS;
        mid();
        chk("w_dwait_done", bus.dwait, 0);
        step();
        bus.dWEN = 1'b0;
        bus.ramstate = R_FREE;
        mid();
        chk("w_gap_idle", dbgState, S_IDLE);
        step();
        bus.ramstate = R_ACCESS;
        bus.ramload = 32'hCAFE;
        mid();
        chk("w_then_ignt", dbgState, S_IGNT);
        chk("w_then_ramaddr", bus.ramaddr, 32'h44);
        step();
        idle_bus();
        step();

        // starvation: iREN held, five back-to-back data reads
        c = cyc;
        bus.iREN = 1'b1;
        bus.dREN = 1'b1;
        bus.ramstate = R_ACCESS;
        expect_ev(K_D, 1'b0, c + 16'd1, 32'h1001);
        expect_ev(K_D, 1'b0, c + 16'd3, 32'h1003);
        expect_ev(K_D, 1'b0, c + 16'd5, 32'h1005);
        expect_ev(K_D, 1'b0, c + 16'd7, 32'h1007);
        expect_ev(K_I, 1'b0, c + 16'd9, 32'h1009);
        expect_ev(K_D, 1'b0, c + 16'd11, 32'h100B);
        for (int j = 0; j < 13; j++) begin
            if (j > 0) step();
            bus.ramload = 32'h1000 + 32'(j);
            if (j == 12) begin
                bus.dREN = 1'b0;
                bus.iREN = 1'b0;
            end
            mid();
            chk($sformatf("starve_state_%0d", j), dbgState, st_tab[j]);
        end
        step();
        idle_bus();
        step();

        // timeout: BUSY forever aborts after 15 grant cycles, then re-arbitrates
        c = cyc;
        bus.dREN = 1'b1;
        bus.daddr = 32'h90;
        bus.ramstate = R_BUSY;
        expect_ev(K_ABT, 1'b1, c + 16'd16, 32'h0);
        expect_ev(K_D, 1'b0, c + 16'd18, 32'h7777);
        for (int k = 1; k <= 15; k++) step();
        mid();
        chk("to_last_grant", dbgState, S_DGNT);
        chk("to_no_err_yet", bus.memerr, 0);
        step();
        mid();
        chk("to_abort", dbgState, S_ABORT);
        chk("to_memerr", bus.memerr, 1);
        chk("to_abort_ramREN", bus.ramREN, 0);
        chk("to_abort_dwait", bus.dwait, 1);
        step();
        mid();
        chk("to_idle", dbgState, S_IDLE);
        chk("to_memerr_once", bus.memerr, 0);
        step();
        bus.ramstate = R_ACCESS;
        bus.ramload = 32'h7777;
        mid();
        chk("to_regrant", dbgState, S_DGNT);
        chk("to_dload", bus.dload, 32'h7777);
        step();
        idle_bus();
        step();

        // mid-grant drop: strobes follow the request, no completion
        c = cyc;
        bus.dREN = 1'b1;
        bus.daddr = 32'hB0;
        bus.ramstate = R_BUSY;
        step();
        mid();
        chk("drop_ramREN_on", bus.ramREN, 1);
        chk("drop_ramaddr", bus.ramaddr, 32'hB0);
        step();
        bus.dREN = 1'b0;
        mid();
        chk("drop_ramREN_off", bus.ramREN, 0);
        chk("drop_memerr", bus.memerr, 0);
        step();
        mid();
        chk("drop_idle", dbgState, S_IDLE);
        idle_bus();
        step();

        // reset mid-grant with ACCESS arriving in the same cycle
        c = cyc;
        bus.dREN = 1'b1;
        bus.daddr = 32'hA0;
        expect_ev(K_D, 1'b0, c + 16'd4, 32'h8888);
        step();
        bus.ramstate = R_BUSY;
        mid();
        chk("rg_state", dbgState, S_DGNT);
        step();
        rst = 1'b1;
        bus.ramstate = R_ACCESS;
        bus.ramload = 32'h9999;
        mid();
        chk("rg_dwait", bus.dwait, 1);
        chk("rg_ramREN", bus.ramREN, 0);
        chk("rg_ramaddr", bus.ramaddr, 0);
        chk("rg_dload", bus.dload, 0);
        chk("rg_state_idle", dbgState, S_IDLE);
        step();
        rst = 1'b0;
        bus.ramstate = R_FREE;
        mid();
        chk("rg_release_idle", dbgState, S_IDLE);
        step();
        bus.ramstate = R_ACCESS;
        bus.ramload = 32'h8888;
        mid();
        chk("rg_regrant", dbgState, S_DGNT);
        step();
        idle_bus();
        step();

        // ERROR during instruction grant
        c = cyc;
        bus.iREN = 1'b1;
        bus.iaddr = 32'h50;
        expect_ev(K_I, 1'b1, c + 16'd1, 32'hBAD0);
        step();
        bus.ramstate = R_ERROR;
        bus.ramload = 32'hBAD0;
        mid();
        chk("err_iwait", bus.iwait, 0);
        chk("err_memerr", bus.memerr, 1);
        step();
        idle_bus();
        mid();
        chk("err_idle", dbgState, S_IDLE);
        chk("err_memerr_clear", bus.memerr, 0);
        step();
        step();

        chk("queue_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
